dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised data-memory controller; successor to the single-cycle data memory in the RISC-V core.
- Word-organised storage with little-endian byte lanes and full RV32I load/store widths: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Valid/ready request and response handshakes with a configurable wait-state count.
- Sits between the core's load/store path and storage, so a multi-cycle core can stall on memory.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of 32-bit words (power of two, 4..4096).
- WAIT_STATES, 1, extra cycles between request accept and response (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 width/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (low bits used for SB/SH)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal funct3
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; wait counter 0; captured request cleared.
- Memory contents: 0 at time 0; not cleared by reset.
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - req_ready=1 only in IDLE.
  - Accept on the clk edge where req_valid&&req_ready; latch write, funct3, addr and wdata.
  - From IDLE: go to WAIT if WAIT_STATES>0, else directly to RESP.
  - WAIT: counts WAIT_STATES cycles, then goes to RESP.
- Latency: rsp_valid rises WAIT_STATES+1 edges after the accept edge.
- Store write and load sampling both occur on the edge entering RESP.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready.
- On the handshake edge, return to IDLE; req_ready=1 the next cycle. No back-to-back accept on the handshake edge.
- rsp_ready is ignored outside RESP; req_valid is ignored outside IDLE.
- Addressing:
  - Word index = addr[ADDR_W-1:2].
  - Byte lane = addr[1:0]; lane 0 = bits [7:0] (little-endian).
- funct3 codes:
  - 000 byte signed, 001 half signed, 010 word.
  - 100 byte unsigned, 101 half unsigned; loads only.
  - Stores accept 000/001/010 only.
- Loads:
  - Byte: selected lane, sign- or zero-extended per funct3.
  - Half: lanes {addr[1],1'b0}+1 : {addr[1],1'b0}, sign- or zero-extended.
  - Word: full word.
- Stores:
  - SB writes only the addressed lane.
  - SH writes two lanes.
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
- Errors: rsp_err=1, memory untouched, rsp_rdata=0 when any of these holds:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - word index >= DEPTH;
  - illegal funct3 (011, 110, 111; or 1xx on a store).
- Error responses obey the same latency and handshake as normal responses.
- Reset mid-operation (WAIT or RESP): return to IDLE immediately. A store still in WAIT is discarded with no memory write. A store already committed in RESP is kept.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined: adds output ports stat_loads[15:0], stat_stores[15:0], stat_errs[15:0].
  - Each increments on the RESP handshake edge of the matching response. Errored requests count only in stat_errs.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store/load word, WAIT_STATES=1: SW addr 0x10, data 0xDEADBEEF; then LW 0x10.
  - rsp_valid 2 cycles after each accept.
  - rdata=0xDEADBEEF, err=0.
- Byte lanes: SW 0x20=0x00000000; SB 0x21=0x80; SH 0x22=0x1234.
  - LW 0x20 -> 0x12348000.
  - LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080.
  - LH 0x22 -> 0x00001234.
- Misaligned and illegal requests:
  - SH 0x31 -> err=1, word 0x30 unchanged.
  - LW 0x32 -> err=1, rdata=0.
  - funct3=011 load -> err=1.
  - Address DEPTH*4 -> err=1.
- Back-pressure: hold rsp_ready=0 for 5 cycles after LW.
  - rsp_valid/rdata stable, req_ready=0, busy=1 throughout.
  - A second req_valid is not accepted until one cycle after the handshake.
- Reset mid-store: SW 0x40=0xCAFEF00D with WAIT_STATES=3; assert reset during WAIT.
  - req_ready=1, rsp_valid=0 immediately.
  - Subsequent LW 0x40 returns the prior value 0x00000000.
- WAIT_STATES=0, and DMEM_STATS_EN defined:
  - Response 1 cycle after accept.
  - After 3 loads, 2 stores and 1 error: counters read 3/2/1; reset clears them.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32I data-memory controller, word storage with little-endian byte lanes,
// valid/ready request/response handshakes, WAIT_STATES wait cycles. Counters under DMEM_STATS_EN.
//
// state  | meaning
// S_IDLE | ready for a request (req_ready=1)
// S_WAIT | wait-state down-counter running toward terminal count 0
// S_RESP | response held until rsp_valid && rsp_ready
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_errs
`endif
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]        WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        wait_cnt_q;
  logic              cap_write;
  logic [2:0]        cap_funct3;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              wait_done;
  logic              enter_resp;
  logic              mem_we;
  logic              op_write;
  logic [2:0]        op_funct3;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic              f3_ok;
  logic              misalign;
  logic              out_of_range;
  logic              op_err;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  logic [3:0]        st_be;
  logic [31:0]       st_data;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    busy      = (state_q != S_IDLE);
    rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
    rsp_err   = (state_q == S_RESP) && err_q;
  end

  assign accept     = req_valid && req_ready;
  assign wait_done  = (state_q == S_WAIT) && (wait_cnt_q == 4'd0);
  assign enter_resp = (accept && (WAIT_STATES == 0)) || wait_done;

  // With zero wait states the commit happens on the accept edge, so decode the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_write  = req_write;
      op_funct3 = req_funct3;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
    end else begin
      op_write  = cap_write;
      op_funct3 = cap_funct3;
      op_addr   = cap_addr;
      op_wdata  = cap_wdata;
    end
  end

  always_comb begin
    if (op_write) f3_ok = op_funct3 inside {3'b000, 3'b001, 3'b010};
    else          f3_ok = op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign     = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                   ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    out_of_range = (op_addr >> 2) >= DEPTH_A;
    op_err       = !f3_ok || misalign || out_of_range;
  end

  assign word_idx = op_addr[IDX_W+1:2];
  assign rd_word  = mem[word_idx];
  assign ld_byte  = rd_word[{op_addr[1:0], 3'b000} +: 8];
  assign ld_half  = rd_word[{op_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (op_funct3[1:0])
      2'b00:   ld_data = {{24{!op_funct3[2] && ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{!op_funct3[2] && ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    case (op_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << op_addr[1:0];
        st_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = op_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{op_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = op_wdata;
      end
    endcase
  end

  // A clock edge while reset is held must never commit a store.
  assign mem_we = enter_resp && op_write && !op_err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
      cap_write  <= 1'b0;
      cap_funct3 <= 3'd0;
      cap_addr   <= '0;
      cap_wdata  <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        cap_write  <= req_write;
        cap_funct3 <= req_funct3;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
        wait_cnt_q <= WAIT_LOAD;
      end else if ((state_q == S_WAIT) && (wait_cnt_q != 4'd0)) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
      if (enter_resp) begin
        err_q   <= op_err;
        rdata_q <= (op_err || op_write) ? 32'd0 : ld_data;
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_loads  <= 16'd0;
      stat_stores <= 16'd0;
      stat_errs   <= 16'd0;
    end else if (rsp_valid && rsp_ready) begin
      if (err_q) begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end else if (cap_write) begin
        if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: three dmem_ctrl instances (WAIT_STATES 1, 3, 0) checked against directed
// vectors and a byte-addressed reference model under random traffic.
module tb_dmem_ctrl;
  localparam int DEPTH = 256;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_write  [NI];
  logic [2:0]  req_funct3 [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        rsp_valid  [NI];
  logic        rsp_ready  [NI];
  logic [31:0] rsp_rdata  [NI];
  logic        rsp_err    [NI];
  logic        busy       [NI];
`ifdef DMEM_STATS_EN
  logic [15:0] stat_loads  [NI];
  logic [15:0] stat_stores [NI];
  logic [15:0] stat_errs   [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int G_WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    dmem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(G_WS)) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .busy       (busy[g])
`ifdef DMEM_STATS_EN
      ,
      .stat_loads (stat_loads[g]),
      .stat_stores(stat_stores[g]),
      .stat_errs  (stat_errs[g])
`endif
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  bit [7:0] mb [NI][DEPTH*4];

  typedef struct {
    bit          wr;
    bit [2:0]    f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  function automatic vec_t mk(input bit wr, input bit [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd, input bit e);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = d; v.exp_rd = rd; v.exp_err = e;
    return v;
  endfunction

  // Reference: byte-addressed memory, access size 1/2/4 bytes, natural alignment required.
  function automatic void model_txn(input int k, input bit wr, input bit [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output bit err);
    int     sz;
    bit     legal;
    longint v;
    sz = 1 << f3[1:0];
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 != 3'd3) && (f3 < 3'd6);
    err = !legal || ((addr % sz) != 0) || (addr >= DEPTH * 4);
    rd  = '0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < sz; i++) mb[k][int'(addr) + i] = 8'(wd >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(mb[k][int'(addr) + i]) << (8 * i));
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v - (longint'(1) << (8 * sz));
      rd = v[31:0];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_req(input int k, input bit wr, input bit [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
    req_valid[k] = 1'b1; req_write[k] = wr; req_funct3[k] = f3;
    req_addr[k] = a; req_wdata[k] = d;
    check("req_ready_before_accept", req_ready[k], 1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, output int lat);
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_valid_within_budget", rsp_valid[k], 1);
  endtask

  task automatic finish_rsp(input int k, input int hold);
    logic [31:0] rd0;
    logic        e0;
    rd0 = rsp_rdata[k];
    e0  = rsp_err[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid[k], 1);
      check("hold_rdata", rsp_rdata[k], rd0);
      check("hold_err", rsp_err[k], e0);
      check("hold_req_ready", req_ready[k], 0);
      check("hold_busy", busy[k], 1);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[k] = 1'b0;
    check("post_hs_rsp_valid", rsp_valid[k], 0);
    check("post_hs_req_ready", req_ready[k], 1);
    check("post_hs_busy", busy[k], 0);
  endtask

  task automatic do_txn(input int k, input bit wr, input bit [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic err, output int lat);
    send_req(k, wr, f3, a, d);
    wait_rsp(k, lat);
    rd  = rsp_rdata[k];
    err = rsp_err[k];
    finish_rsp(k, hold);
  endtask

  task automatic run_vec(input int k, input string name, input vec_t v);
    logic [31:0] rd, mrd;
    logic        err;
    bit          merr;
    int          lat;
    do_txn(k, v.wr, v.f3, v.addr, v.wdata, 0, rd, err, lat);
    model_txn(k, v.wr, v.f3, v.addr, v.wdata, mrd, merr);
    check({name, "_latency"}, lat, ws_of(k) + 1);
    check({name, "_rdata"}, rd, v.exp_rd);
    check({name, "_err"}, err, v.exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, a, d;
    logic        err;
    bit          exp_err, wr;
    bit [2:0]    f3;
    int          lat;

    for (int k = 0; k < NI; k++) begin
      reset[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_funct3[k] = 3'd0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset%0d_req_ready", k), req_ready[k], 1);
      check($sformatf("reset%0d_rsp_valid", k), rsp_valid[k], 0);
      check($sformatf("reset%0d_rdata", k), rsp_rdata[k], 0);
      check($sformatf("reset%0d_err", k), rsp_err[k], 0);
      check($sformatf("reset%0d_busy", k), busy[k], 0);
      reset[k] = 1'b0;
    end

    // Directed vectors on the WAIT_STATES=1 instance.
    vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 3'b010, 32'h20, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h21, 32'h80, 32'h0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h22, 32'h1234, 32'h0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'h12348000, 0));
    vecs.push_back(mk(0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk(0, 3'b001, 32'h22, 32'h0, 32'h00001234, 0));
    vecs.push_back(mk(0, 3'b001, 32'h20, 32'h0, 32'hFFFF8000, 0));
    vecs.push_back(mk(0, 3'b101, 32'h20, 32'h0, 32'h00008000, 0));
    vecs.push_back(mk(1, 3'b010, 32'h30, 32'h11223344, 32'h0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h31, 32'hAAAA, 32'h0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h30, 32'h0, 32'h11223344, 0));
    vecs.push_back(mk(0, 3'b010, 32'h32, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b011, 32'h30, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h400, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 3'b100, 32'h30, 32'hFF, 32'h0, 1));
    vecs.push_back(mk(0, 3'b100, 32'h33, 32'h0, 32'h00000011, 0));
    vecs.push_back(mk(0, 3'b001, 32'h32, 32'h0, 32'h00001122, 0));
    vecs.push_back(mk(0, 3'b010, 32'h30, 32'h0, 32'h11223344, 0));
    foreach (vecs[i]) run_vec(0, $sformatf("vec%0d", i), vecs[i]);

    // Back-pressure with a competing request held during RESP.
    send_req(0, 0, 3'b010, 32'h10, 32'h0);
    wait_rsp(0, lat);
    check("bp_latency", lat, 2);
    check("bp_rdata", rsp_rdata[0], 32'hDEADBEEF);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h20;
    finish_rsp(0, 5);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("bp_second_accepted", busy[0], 1);
    wait_rsp(0, lat);
    check("bp_second_latency", lat, 2);
    check("bp_second_rdata", rsp_rdata[0], 32'h12348000);
    finish_rsp(0, 0);

    // Reset during WAIT discards the store (WAIT_STATES=3 instance).
    send_req(1, 1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("mid_wait_busy", busy[1], 1);
    reset[1] = 1'b1;
    #1;
    check("rst_wait_req_ready", req_ready[1], 1);
    check("rst_wait_rsp_valid", rsp_valid[1], 0);
    check("rst_wait_busy", busy[1], 0);
    @(posedge clk); #1;
    reset[1] = 1'b0;
    run_vec(1, "rst_wait_lw", mk(0, 3'b010, 32'h40, 32'h0, 32'h0, 0));

    // Reset during RESP keeps the committed store.
    send_req(1, 1, 3'b010, 32'h44, 32'h00000055);
    wait_rsp(1, lat);
    check("commit_latency", lat, 4);
    reset[1] = 1'b1;
    #1;
    check("rst_resp_rsp_valid", rsp_valid[1], 0);
    check("rst_resp_req_ready", req_ready[1], 1);
    @(posedge clk); #1;
    reset[1] = 1'b0;
    model_txn(1, 1, 3'b010, 32'h44, 32'h00000055, rd, exp_err);
    run_vec(1, "rst_resp_lw", mk(0, 3'b010, 32'h44, 32'h0, 32'h00000055, 0));

    // WAIT_STATES=0: 2 stores, 3 loads, 1 error.
    run_vec(2, "ws0_sw0", mk(1, 3'b010, 32'h80, 32'h00000001, 32'h0, 0));
    run_vec(2, "ws0_sw1", mk(1, 3'b010, 32'h84, 32'h000000F2, 32'h0, 0));
    run_vec(2, "ws0_lw0", mk(0, 3'b010, 32'h80, 32'h0, 32'h00000001, 0));
    run_vec(2, "ws0_lw1", mk(0, 3'b010, 32'h84, 32'h0, 32'h000000F2, 0));
    run_vec(2, "ws0_lb",  mk(0, 3'b000, 32'h84, 32'h0, 32'hFFFFFFF2, 0));
    run_vec(2, "ws0_err", mk(0, 3'b010, 32'h81, 32'h0, 32'h0, 1));
`ifdef DMEM_STATS_EN
    check("stat_loads", stat_loads[2], 3);
    check("stat_stores", stat_stores[2], 2);
    check("stat_errs", stat_errs[2], 1);
    reset[2] = 1'b1;
    #1;
    check("stat_loads_rst", stat_loads[2], 0);
    check("stat_stores_rst", stat_stores[2], 0);
    check("stat_errs_rst", stat_errs[2], 0);
    @(posedge clk); #1;
    reset[2] = 1'b0;
`endif

    // Random traffic against the reference model.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 120; n++) begin
        int r;
        wr = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        d  = $urandom;
        r  = $urandom_range(0, 9);
        if (r == 0)      a = 32'(DEPTH * 4 + $urandom_range(0, 15));
        else if (r == 1) a = $urandom;
        else             a = 32'($urandom_range(0, 63));
        model_txn(k, wr, f3, a, d, exp_rd, exp_err);
        do_txn(k, wr, f3, a, d, $urandom_range(0, 2), rd, err, lat);
        check($sformatf("rnd%0d_%0d_latency", k, n), lat, ws_of(k) + 1);
        check($sformatf("rnd%0d_%0d_rdata", k, n), rd, exp_rd);
        check($sformatf("rnd%0d_%0d_err", k, n), err, exp_err);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
